// File: rtl/ixu_alu_sched.sv
// Round-robin scheduler sharing one 32-bit integer ALU among NREQ issue slots,
// with a single-entry registered result stage and valid/ready handshake.
module ixu_alu_sched #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 4,
    localparam int SRC_W = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][3:0]        req_op,
    input  logic [NREQ-1:0][31:0]       req_x,
    input  logic [NREQ-1:0][31:0]       req_y,
    input  logic [NREQ-1:0][TAG_W-1:0]  req_tag,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [31:0]                 res_data,
    output logic [SRC_W-1:0]            res_src,
    output logic [TAG_W-1:0]            res_tag,
    output logic                        res_err
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_OR  = 4'h3, OP_AND = 4'h4,
        OP_SLL  = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7, OP_SLT = 4'h8, OP_SLTU = 4'h9
    } op_e;

    // Returns {err, data}; shift amounts use all 32 bits of y.
    function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
        logic       big;
        logic [4:0] sh;
        logic [32:0] r;
        big = |y[31:5];
        sh  = y[4:0];
        r   = {1'b0, 32'h0000_0000};
        case (op)
            OP_ADD:  r[31:0] = x + y;
            OP_SUB:  r[31:0] = x - y;
            OP_XOR:  r[31:0] = x ^ y;
            OP_OR:   r[31:0] = x | y;
            OP_AND:  r[31:0] = x & y;
            OP_SLL:  r[31:0] = big ? 32'h0000_0000 : (x << sh);
            OP_SRL:  r[31:0] = big ? 32'h0000_0000 : (x >> sh);
            OP_SRA:  r[31:0] = big ? {32{x[31]}} : 32'($signed(x) >>> sh);
            OP_SLT:  r[31:0] = {31'h0, ($signed(x) < $signed(y))};
            OP_SLTU: r[31:0] = {31'h0, (x < y)};
            default: r = {1'b1, 32'hDEAD_BEEF};
        endcase
        return r;
    endfunction

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              err_q, err_d;
    logic              can_accept_s, found_s, grant_s;
    logic [SRC_W-1:0]  win_s;
    logic [32:0]       alu_s;
    int                idx_s;

    // Arbiter: first requester at or after rr_ptr (with wrap) wins.
    always_comb begin
        can_accept_s = !rst && !flush && (!valid_q || res_ready);
        found_s      = 1'b0;
        win_s        = '0;
        idx_s        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = int'(rr_ptr_q) + k;
            if (idx_s >= NREQ) begin
                idx_s = idx_s - NREQ;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s[SRC_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
        grant_s   = can_accept_s && found_s;
        req_ready = '0;
        if (grant_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign alu_s = alu_f(req_op[win_s], req_x[win_s], req_y[win_s]);

    // Next state of the result stage and round-robin pointer; flush beats res_ready.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        src_d    = src_q;
        tag_d    = tag_q;
        err_d    = err_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (grant_s) begin
            valid_d  = 1'b1;
            data_d   = alu_s[31:0];
            err_d    = alu_s[32];
            src_d    = win_s;
            tag_d    = req_tag[win_s];
            rr_ptr_d = (win_s == SRC_W'(NREQ - 1)) ? '0 : (win_s + SRC_W'(1));
        end else if (res_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers; reset drops any held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= 32'h0000_0000;
            src_q    <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            src_q    <= src_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
        end
    end

    assign res_valid = valid_q;
    assign res_data  = data_q;
    assign res_src   = src_q;
    assign res_tag   = tag_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_ixu_alu_sched.sv
// Directed bench for ixu_alu_sched: a reference arbiter/ALU model feeds a
// scoreboard queue that is drained whenever a result is consumed.
module tb_ixu_alu_sched;

    logic              clk = 1'b0;
    logic              rst, flush, res_ready;
    logic [3:0]        req_valid, req_ready;
    logic [3:0][3:0]   req_op;
    logic [3:0][31:0]  req_x, req_y;
    logic [3:0][3:0]   req_tag;
    logic              res_valid, res_err;
    logic [31:0]       res_data;
    logic [1:0]        res_src;
    logic [3:0]        res_tag;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
        logic [3:0]  t;
        logic        e;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    logic m_valid = 1'b0;
    int   m_ptr = 0;

    ixu_alu_sched #(.NREQ(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_src(res_src), .res_tag(res_tag), .res_err(res_err)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] ext;
        logic        over;
        over = (y > 32'd31);
        ext  = {{32{x[31]}}, x};
        if (op == 4'd0) return {1'b0, x + y};
        if (op == 4'd1) return {1'b0, x + ~y + 32'd1};
        if (op == 4'd2) return {1'b0, (x | y) & ~(x & y)};
        if (op == 4'd3) return {1'b0, x | y};
        if (op == 4'd4) return {1'b0, x & y};
        if (op == 4'd5) return over ? 33'd0 : {1'b0, x << y[4:0]};
        if (op == 4'd6) return over ? 33'd0 : {1'b0, x >> y[4:0]};
        if (op == 4'd7) return over ? {1'b0, {32{x[31]}}} : {1'b0, ext[31:0] >> 0} & 33'h0 | {1'b0, 32'(ext >> y[4:0])};
        if (op == 4'd8) return {32'd0, ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000))};
        if (op == 4'd9) return {32'd0, (x < y)};
        return {1'b1, 32'hDEAD_BEEF};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check against the model just before the edge, update model, advance.
    task automatic tick();
        exp_t       e;
        logic       can;
        int         w, i;
        logic [3:0] er;
        logic [32:0] r;
        #1;
        can = !rst && !flush && (!m_valid || res_ready);
        w = -1;
        for (int k = 0; k < 4; k++) begin
            i = (m_ptr + k) % 4;
            if (w < 0 && req_valid[i]) w = i;
        end
        er = (can && w >= 0) ? 4'(1 << w) : 4'h0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        if (m_valid && flush) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else if (m_valid && res_ready) begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("res_data", res_data, e.d);
                chk("res_src", 32'(res_src), 32'(e.s));
                chk("res_tag", 32'(res_tag), 32'(e.t));
                chk("res_err", 32'(res_err), 32'(e.e));
            end else begin
                failures++;
                $error("FAIL sb_underflow observed=result expected=none");
            end
        end
        if (flush) begin
            m_valid = 1'b0;
        end else if (can && w >= 0) begin
            r = ref_alu(req_op[w], req_x[w], req_y[w]);
            e.d = r[31:0];
            e.e = r[32];
            e.s = 2'(w);
            e.t = req_tag[w];
            sbq.push_back(e);
            m_valid = 1'b1;
            m_ptr = (w + 1) % 4;
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0]  t4_op  [4] = '{4'h7, 4'h9, 4'h8, 4'hC};
    logic [31:0] t4_x   [4] = '{32'h8000_0000, 32'h1, 32'h1, 32'h0};
    logic [31:0] t4_y   [4] = '{32'd40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] t4_res [4] = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'hDEAD_BEEF};
    logic        t4_err [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
        req_valid = 4'hF; req_op = '0; req_x = '0; req_y = '0; req_tag = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_res_src", 32'(res_src), 32'h0);
        chk("rst_res_tag", 32'(res_tag), 32'h0);
        chk("rst_res_err", 32'(res_err), 32'h0);
        rst = 1'b0; req_valid = 4'h0;
        @(negedge clk);

        // 1: single ADD 7 + (-3)
        req_valid = 4'b0001; req_op[0] = 4'h0; req_x[0] = 32'd7; req_y[0] = 32'hFFFF_FFFD; req_tag[0] = 4'd5;
        tick();
        req_valid = 4'h0;
        chk("t1_data", res_data, 32'd4);
        chk("t1_src", 32'(res_src), 32'd0);
        chk("t1_tag", 32'(res_tag), 32'd5);
        tick();

        // 2: all four requesters continuously valid
        for (int i = 0; i < 4; i++) begin
            req_op[i] = 4'(i); req_x[i] = 32'h1234_0000 + 32'(i * 17); req_y[i] = 32'h0F0F_00F0 + 32'(i);
            req_tag[i] = 4'(i + 8);
        end
        req_valid = 4'hF;
        repeat (5) tick();

        // 3: consumer stalls for three cycles
        res_ready = 1'b0;
        repeat (3) tick();
        res_ready = 1'b1;
        tick();
        req_valid = 4'h0;
        tick();

        // 4: shift/compare/illegal corner cases, back to back from requester 0
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001; req_op[0] = t4_op[i]; req_x[0] = t4_x[i]; req_y[0] = t4_y[i];
            req_tag[0] = 4'(i);
            tick();
            chk("t4_data", res_data, t4_res[i]);
            chk("t4_err", 32'(res_err), 32'(t4_err[i]));
        end

        // 5: flush a held result while requester 1 waits
        req_valid = 4'b0010; req_op[1] = 4'h5; req_x[1] = 32'h3; req_y[1] = 32'd4; req_tag[1] = 4'hA;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        req_valid = 4'h0;
        chk("t5_data", res_data, 32'h30);

        // 6: asynchronous reset while holding a result, pointer at 2
        req_valid = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("t6_res_valid", 32'(res_valid), 32'h0);
        chk("t6_res_data", res_data, 32'h0);
        chk("t6_res_src", 32'(res_src), 32'h0);
        chk("t6_req_ready", 32'(req_ready), 32'h0);
        sbq.delete();
        m_valid = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t6_src_after", 32'(res_src), 32'h0);
        req_valid = 4'h0;
        repeat (2) tick();
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
